db_mem_bank: RTL and testbench

- Parametrised successor to the fixed 36-pixel descriptor template store in the FAST9 matcher path.
- Holds NUM_ENT descriptor templates of NUM_PIX pixels at PIX_W bits each.
- Templates are loaded serially, one pixel per cycle, through a staging buffer and committed atomically.
- Serves indexed, single-cycle-latency full-vector reads to the matcher.

---
 rtl/db_mem_pkg.sv | 38 +++
 rtl/db_mem_sad.sv | 39 +++
 rtl/db_mem_bank.sv | 192 +++++++++++++++++++
 tb/tb_db_mem_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/db_mem_pkg.sv
// -----------------------------------------------------------------------------
// db_mem_pkg
// Shared definitions for the descriptor template store (db_mem_bank) and its
// optional SAD helper (db_mem_sad).
//   - default geometry (PIX_W_DEF, NUM_PIX_DEF, NUM_ENT_DEF)
//   - width helpers dbW / idxW / sadW
//   - load FSM state encoding
//   - DEFAULT_TEMPLATE: reference 36 x 8-bit template, pixel 0 in the MSBs
// -----------------------------------------------------------------------------
package db_mem_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int NUM_PIX_DEF = 36;
  localparam int NUM_ENT_DEF = 4;

  function automatic int dbW(input int pixW, input int numPix);
    return pixW * numPix;
  endfunction

  function automatic int idxW(input int numEnt);
    return (numEnt > 1) ? $clog2(numEnt) : 1;
  endfunction

  // Worst case is NUM_PIX * (2**PIX_W - 1); one spare bit keeps the
  // all-ones "no hit" marker distinct from any real sum.
  function automatic int sadW(input int pixW, input int numPix);
    return pixW + $clog2(numPix) + 1;
  endfunction

  typedef enum logic {IDLE, LOAD} loadState_t;

  localparam logic [NUM_PIX_DEF*PIX_W_DEF-1:0] DEFAULT_TEMPLATE = {
    {4{8'd95}}, {4{8'd0}}, {4{8'd95}}, {2{8'd159}}, {2{8'd255}},
    {4{8'd159}}, {2{8'd255}}, {2{8'd159}}, {4{8'd95}}, {4{8'd0}},
    {4{8'd95}}
  };

endpackage

// File: rtl/db_mem_sad.sv
// -----------------------------------------------------------------------------
// db_mem_sad
// Purely combinational sum of absolute differences between a stored template
// and a search window, both NUM_PIX pixels of PIX_W unsigned bits.
// Only compiled when DB_MEM_BANK_SAD_EN is defined.
// Ports:
//   tmpl  in  DB_W   template vector, pixel 0 in the MSBs
//   win   in  DB_W   window vector, same packing
//   sad   out SAD_W  sum over pixels of |tmpl - win|
// -----------------------------------------------------------------------------
`ifdef DB_MEM_BANK_SAD_EN
module db_mem_sad
  import db_mem_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int NUM_PIX = NUM_PIX_DEF,
  localparam int DB_W   = dbW(PIX_W, NUM_PIX),
  localparam int SAD_W  = sadW(PIX_W, NUM_PIX)
)(
  input  logic [DB_W-1:0]  tmpl,
  input  logic [DB_W-1:0]  win,
  output logic [SAD_W-1:0] sad
);

  function automatic logic [PIX_W-1:0] absDiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    sad = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      sad = sad + SAD_W'(absDiff(tmpl[DB_W-1-i*PIX_W -: PIX_W],
                                 win[DB_W-1-i*PIX_W -: PIX_W]));
    end
  end

endmodule
`endif

// File: rtl/db_mem_bank.sv
// -----------------------------------------------------------------------------
// db_mem_bank
// Store of NUM_ENT descriptor templates (NUM_PIX pixels x PIX_W bits each).
// Templates are streamed in one pixel per cycle into a staging buffer and
// committed to their entry atomically on the last pixel, so a reader never
// sees a half-written template. Reads return a full vector one cycle later.
// Optional feature macro: DB_MEM_BANK_SAD_EN (adds win_in / rd_sad).
// Ports:
//   clk, reset            clock, async active-high reset
//   wr_start, wr_idx      begin a load into entry wr_idx (ignored while busy)
//   wr_en, wr_pix         pixel strobe / data, first pixel -> MSB slot
//   wr_busy, wr_done      load in progress / one-cycle commit-done pulse
//   rd_req, rd_idx        read request / entry index
//   rd_valid, rd_hit      response strobe / entry held a committed template
//   rd_data               template, pixel 0 in [DB_W-1 -: PIX_W]
//   ent_valid             per-entry committed flags
//   win_in, rd_sad        (SAD build) window vector / registered SAD
// -----------------------------------------------------------------------------
module db_mem_bank
  import db_mem_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int NUM_PIX = NUM_PIX_DEF,
  parameter int NUM_ENT = NUM_ENT_DEF,
  localparam int DB_W   = dbW(PIX_W, NUM_PIX),
  localparam int IDX_W  = idxW(NUM_ENT)
`ifdef DB_MEM_BANK_SAD_EN
  ,
  localparam int SAD_W  = sadW(PIX_W, NUM_PIX)
`endif
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_start,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_en,
  input  logic [PIX_W-1:0]   wr_pix,
  output logic               wr_busy,
  output logic               wr_done,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic               rd_hit,
  output logic [DB_W-1:0]    rd_data,
  output logic [NUM_ENT-1:0] ent_valid
`ifdef DB_MEM_BANK_SAD_EN
  ,
  input  logic [DB_W-1:0]    win_in,
  output logic [SAD_W-1:0]   rd_sad
`endif
);

  localparam int CNT_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);

  loadState_t         state;
  loadState_t         stateNext;
  logic [IDX_W-1:0]   ldIdx;
  logic [CNT_W-1:0]   pixCnt;
  logic               startAcc;
  logic               pixWe;
  logic               commit;

  logic [PIX_W-1:0]   stage [NUM_PIX];
  logic [DB_W-1:0]    commitVec;
  logic [DB_W-1:0]    mem [NUM_ENT];
  logic [NUM_ENT-1:0] entValid;

  logic               rdInRange_p0;
  logic [IDX_W-1:0]   rdSafe_p0;
  logic               rdHit_p0;

  // ---------------------------------------------------------------- load FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ldIdx   <= '0;
      pixCnt  <= '0;
      wr_done <= 1'b0;
    end else begin
      state   <= stateNext;
      wr_done <= commit;
      if (startAcc) begin
        ldIdx  <= wr_idx;
        pixCnt <= '0;
      end else if (pixWe) begin
        pixCnt <= pixCnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    startAcc  = 1'b0;
    pixWe     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_start) begin
          startAcc  = 1'b1;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (wr_en) begin
          pixWe = 1'b1;
          if (pixCnt == LAST_PIX) begin
            commit    = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign wr_busy = (state == LOAD);

  // ------------------------------------------------------- staging / commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIX; i++) stage[i] <= '0;
    end else if (pixWe) begin
      stage[pixCnt] <= wr_pix;
    end
  end

  // The last pixel bypasses the staging buffer so the commit happens on the
  // same cycle it arrives.
  always_comb begin
    commitVec = '0;
    for (int i = 0; i < NUM_PIX - 1; i++) begin
      commitVec[DB_W-1-i*PIX_W -: PIX_W] = stage[i];
    end
    commitVec[PIX_W-1:0] = wr_pix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < NUM_ENT; e++) mem[e] <= '0;
      entValid <= '0;
    end else if (commit && (int'(ldIdx) < NUM_ENT)) begin
      mem[ldIdx]      <= commitVec;
      entValid[ldIdx] <= 1'b1;
    end
  end

  assign ent_valid = entValid;

  // --------------------------------------------- read: request (p0) -> resp
  // Response registers sample mem/entValid before any same-edge commit lands,
  // so a read racing a commit returns the old template.
  assign rdInRange_p0 = (int'(rd_idx) < NUM_ENT);
  assign rdSafe_p0    = rdInRange_p0 ? rd_idx : '0;
  assign rdHit_p0     = rdInRange_p0 && entValid[rdSafe_p0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_hit  <= rdHit_p0;
        rd_data <= rdHit_p0 ? mem[rdSafe_p0] : '0;
      end
    end
  end

`ifdef DB_MEM_BANK_SAD_EN
  logic [SAD_W-1:0] sad_p0;

  db_mem_sad #(
    .PIX_W   (PIX_W),
    .NUM_PIX (NUM_PIX)
  ) uSad (
    .tmpl (mem[rdSafe_p0]),
    .win  (win_in),
    .sad  (sad_p0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sad <= '1;
    end else if (rd_req) begin
      rd_sad <= rdHit_p0 ? sad_p0 : '1;
    end
  end
`endif

endmodule

// File: tb/tb_db_mem_bank.sv
// -----------------------------------------------------------------------------
// tb_db_mem_bank
// Directed self-checking bench for db_mem_bank (default geometry 8 x 36 x 4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// that same point, i.e. they reflect the most recent edge.
// -----------------------------------------------------------------------------
module tb_db_mem_bank;
  import db_mem_pkg::*;

  localparam int PIX_W   = 8;
  localparam int NUM_PIX = 36;
  localparam int NUM_ENT = 4;
  localparam int DB_W    = PIX_W * NUM_PIX;
  localparam int IDX_W   = 2;
`ifdef DB_MEM_BANK_SAD_EN
  localparam int SAD_W   = 15;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_start;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_en;
  logic [PIX_W-1:0]   wr_pix;
  logic               wr_busy;
  logic               wr_done;
  logic               rd_req;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid;
  logic               rd_hit;
  logic [DB_W-1:0]    rd_data;
  logic [NUM_ENT-1:0] ent_valid;
`ifdef DB_MEM_BANK_SAD_EN
  logic [DB_W-1:0]    win_in;
  logic [SAD_W-1:0]   rd_sad;
`endif

  int total = 0;
  int bad   = 0;

  logic [DB_W-1:0] tmplDef;
  logic [DB_W-1:0] tmplSeven;

  db_mem_bank dut (
    .clk       (clk),
    .reset     (reset),
    .wr_start  (wr_start),
    .wr_idx    (wr_idx),
    .wr_en     (wr_en),
    .wr_pix    (wr_pix),
    .wr_busy   (wr_busy),
    .wr_done   (wr_done),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .ent_valid (ent_valid)
`ifdef DB_MEM_BANK_SAD_EN
    ,
    .win_in    (win_in),
    .rd_sad    (rd_sad)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [IDX_W-1:0] idx);
    wr_start = 1'b1;
    wr_idx   = idx;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic drive_pixels(input logic [DB_W-1:0] vec, input int n, output int doneSeen);
    doneSeen = 0;
    for (int p = 0; p < n; p++) begin
      wr_en  = 1'b1;
      wr_pix = vec[DB_W-1-p*PIX_W -: PIX_W];
      tick();
      if (wr_done) doneSeen++;
    end
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [IDX_W-1:0] idx);
    rd_req = 1'b1;
    rd_idx = idx;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", wr_busy); end
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", wr_done); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rdvalid got=%b want=0", rd_valid); end
    total++; if (ent_valid !== 4'b0000) begin bad++; $display("FAIL rst_entvalid got=%b want=0000", ent_valid); end
    do_read(2'd0);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rst_read_valid got=%b want=1", rd_valid); end
    total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL rst_read_hit got=%b want=0", rd_hit); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_read_data got=%h want=0", rd_data); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_read_strobe got=%b want=0", rd_valid); end
  endtask

  task automatic test_load_read();
    int done;
    start_load(2'd2);
    total++; if (wr_busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b want=1", wr_busy); end
    drive_pixels(tmplDef, NUM_PIX, done);
    total++; if (done != 1) begin bad++; $display("FAIL load_done_count got=%0d want=1", done); end
    total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL load_busy_end got=%b want=0", wr_busy); end
    total++; if (ent_valid !== 4'b0100) begin bad++; $display("FAIL load_entvalid got=%b want=0100", ent_valid); end
    tick();
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b want=0", wr_done); end
    do_read(2'd2);
    total++; if (rd_hit !== 1'b1) begin bad++; $display("FAIL load_read_hit got=%b want=1", rd_hit); end
    total++; if (rd_data !== tmplDef) begin bad++; $display("FAIL load_read_data got=%h want=%h", rd_data, tmplDef); end
    do_read(2'd1);
    total++; if (rd_hit !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL load_read_other got hit=%b data=%h want hit=0 data=0", rd_hit, rd_data); end
  endtask

  task automatic test_reload();
    int done;
    start_load(2'd2);
    drive_pixels(tmplSeven, NUM_PIX - 1, done);
    total++; if (ent_valid !== 4'b0100) begin bad++; $display("FAIL reload_entvalid_mid got=%b want=0100", ent_valid); end
    // Last pixel and a read of the same entry share the commit cycle.
    wr_en  = 1'b1;
    wr_pix = 8'd7;
    rd_req = 1'b1;
    rd_idx = 2'd2;
    tick();
    wr_en = 1'b0;
    total++; if (wr_done !== 1'b1) begin bad++; $display("FAIL reload_done got=%b want=1", wr_done); end
    total++; if (rd_hit !== 1'b1) begin bad++; $display("FAIL reload_race_hit got=%b want=1", rd_hit); end
    total++; if (rd_data !== tmplDef) begin bad++; $display("FAIL reload_race_data got=%h want=%h", rd_data, tmplDef); end
    // rd_req held high: back-to-back read sees the new template.
    tick();
    rd_req = 1'b0;
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", rd_valid); end
    total++; if (rd_data !== tmplSeven) begin bad++; $display("FAIL b2b_data got=%h want=%h", rd_data, tmplSeven); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b want=0", rd_valid); end
    total++; if (rd_data !== tmplSeven || rd_hit !== 1'b1) begin bad++; $display("FAIL hold_data got hit=%b data=%h want hit=1 data=%h", rd_hit, rd_data, tmplSeven); end
  endtask

  task automatic test_reset_abort();
    int done;
    start_load(2'd1);
    drive_pixels(tmplDef, 20, done);
    reset = 1'b1;
    #2;
    total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", wr_busy); end
    total++; if (ent_valid !== 4'b0000) begin bad++; $display("FAIL abort_entvalid got=%b want=0000", ent_valid); end
    tick();
    reset = 1'b0;
    tick();
    do_read(2'd1);
    total++; if (rd_hit !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL abort_read1 got hit=%b data=%h want hit=0 data=0", rd_hit, rd_data); end
    do_read(2'd2);
    total++; if (rd_hit !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL abort_read2 got hit=%b data=%h want hit=0 data=0", rd_hit, rd_data); end
  endtask

  task automatic test_ignored();
    int done;
    // Stray pixels while idle must not advance anything.
    wr_en  = 1'b1;
    wr_pix = 8'hAA;
    repeat (3) tick();
    wr_en = 1'b0;
    total++; if (wr_busy !== 1'b0 || ent_valid !== 4'b0000) begin bad++; $display("FAIL idle_wren got busy=%b ev=%b want busy=0 ev=0000", wr_busy, ent_valid); end
    start_load(2'd0);
    done = 0;
    for (int p = 0; p < NUM_PIX; p++) begin
      wr_en    = 1'b1;
      wr_pix   = tmplDef[DB_W-1-p*PIX_W -: PIX_W];
      wr_start = (p == 10);
      wr_idx   = (p == 10) ? 2'd3 : 2'd0;
      tick();
      if (wr_done) done++;
    end
    wr_en    = 1'b0;
    wr_start = 1'b0;
    total++; if (done != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done); end
    total++; if (ent_valid !== 4'b0001) begin bad++; $display("FAIL ign_entvalid got=%b want=0001", ent_valid); end
    total++; if (wr_busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b want=0", wr_busy); end
    do_read(2'd0);
    total++; if (rd_hit !== 1'b1 || rd_data !== tmplDef) begin bad++; $display("FAIL ign_read0 got hit=%b data=%h want hit=1 data=%h", rd_hit, rd_data, tmplDef); end
    do_read(2'd3);
    total++; if (rd_hit !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL ign_read3 got hit=%b data=%h want hit=0 data=0", rd_hit, rd_data); end
  endtask

`ifdef DB_MEM_BANK_SAD_EN
  task automatic test_sad();
    // Entry 0 holds DEFAULT_TEMPLATE. Only pixel 0 differs: |95-100| = 5.
    win_in = tmplDef;
    win_in[DB_W-1 -: PIX_W] = 8'd100;
    do_read(2'd0);
    total++; if (rd_sad !== 15'd5) begin bad++; $display("FAIL sad_one_pix got=%0d want=5", rd_sad); end
    // Zero window: sum of template pixels =
    // 12*95*... : 95*16 + 159*8 + 255*4 + 0*8 = 1520 + 1272 + 1020 = 3812.
    win_in = '0;
    do_read(2'd0);
    total++; if (rd_sad !== 15'd3812) begin bad++; $display("FAIL sad_zero_win got=%0d want=3812", rd_sad); end
    do_read(2'd3);
    total++; if (rd_sad !== 15'h7FFF) begin bad++; $display("FAIL sad_miss got=%h want=7fff", rd_sad); end
  endtask
`endif

  initial begin
    tmplDef   = DEFAULT_TEMPLATE;
    tmplSeven = {NUM_PIX{8'd7}};
    reset     = 1'b1;
    wr_start  = 1'b0;
    wr_idx    = '0;
    wr_en     = 1'b0;
    wr_pix    = '0;
    rd_req    = 1'b0;
    rd_idx    = '0;
`ifdef DB_MEM_BANK_SAD_EN
    win_in    = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    test_reset();
    test_load_read();
    test_reload();
    test_reset_abort();
    test_ignored();
`ifdef DB_MEM_BANK_SAD_EN
    test_sad();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
